pipe_intr_pic: RTL and testbench

//  Programmable interrupt controller in front of the IU intr/inta handshake.

---
 rtl/pipe_intr_pic_pkg.sv | 15 +
 rtl/pipe_intr_pic_prio_enc.sv | 25 ++
 rtl/pipe_intr_pic.sv | 123 ++++++++++++
 tb/tb_pipe_intr_pic.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_intr_pic_pkg.sv
// pic_pkg: shared types and register map for the pipe_intr_pic interrupt controller.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

endpackage

// File: rtl/pipe_intr_pic_prio_enc.sv
// pic_prio_enc: fixed-priority encoder, lowest set index wins. Purely combinational.
module pic_prio_enc
    import pic_pkg::*;
#(
    parameter int unsigned NSRC = 8,
    parameter int unsigned IDW  = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] vec,
    output logic [IDW-1:0]  id,
    output logic            any
);

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        id  = '0;
        any = 1'b0;
        for (int unsigned i = NSRC; i > 0; i--) begin
            if (vec[i-1]) begin
                id  = IDW'(i - 1);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_intr_pic.sv
// pipe_intr_pic: programmable interrupt controller driving the IU intr/inta handshake.
// Per-source mask and edge/level select, fixed priority (bit 0 highest), vector held
// from commit through inta, in-service until EOI.
// Optional: define PIC_SYNC_EN to pass irq_src through a 2-flop synchronizer.
module pipe_intr_pic
    import pic_pkg::*;
#(
    parameter int unsigned NSRC = 8,
    parameter int unsigned IDW  = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata,
    output logic            intr,
    input  logic            inta,
    output logic [IDW-1:0]  vec_id,
    output logic            in_svc,
    input  logic            eoi
);

    logic [NSRC-1:0] mask_q, edge_q, pend_q, prev_q;
    logic [NSRC-1:0] src, rise, pend_eff, req_vec, clr;
    logic [IDW-1:0]  vec_q, win_id;
    logic            win_any, pend_wr, ack;
    state_t          state_q;
    logic            unused_wdata;

    assign unused_wdata = ^cfg_wdata;

`ifdef PIC_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer per source bit ahead of edge detect / level use.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src = sync2_q;
`else
    assign src = irq_src;
`endif

    assign rise     = src & ~prev_q;
    // Level sources bypass the sticky register and read the live line.
    assign pend_eff = (pend_q & edge_q) | (src & ~edge_q);
    assign req_vec  = pend_eff & mask_q;
    assign pend_wr  = cfg_we && (cfg_addr == ADDR_PEND);
    assign ack      = (state_q == REQ) && inta;

    pic_prio_enc #(.NSRC(NSRC), .IDW(IDW)) u_prio_enc (
        .vec (req_vec),
        .id  (win_id),
        .any (win_any)
    );

    // Pending-clear sources: W1C write and acknowledge of the committed vector.
    always_comb begin
        clr = '0;
        if (pend_wr) clr = cfg_wdata[NSRC-1:0];
        if (ack)     clr[vec_q] = 1'b1;
    end

    // Config registers, edge-pending storage and previous-sample register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            edge_q <= '0;
            pend_q <= '0;
            prev_q <= '0;
        end else begin
            if (cfg_we && (cfg_addr == ADDR_MASK)) mask_q <= cfg_wdata[NSRC-1:0];
            if (cfg_we && (cfg_addr == ADDR_EDGE)) edge_q <= cfg_wdata[NSRC-1:0];
            // A new rising edge beats any clear arriving in the same cycle.
            pend_q <= ((pend_q & ~clr) | rise) & edge_q;
            prev_q <= src;
        end
    end

    // Handshake FSM: commit winner, wait for inta, then hold until eoi.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (win_any) begin
                    state_q <= REQ;
                    vec_q   <= win_id;
                end
                REQ:  if (inta) state_q <= SVC;
                SVC:  if (eoi)  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign intr   = (state_q == REQ);
    assign in_svc = (state_q == SVC);
    assign vec_id = vec_q;

    // Combinational register readback, zero-extended to 32 bits.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_MASK: cfg_rdata = 32'(mask_q);
            ADDR_EDGE: cfg_rdata = 32'(edge_q);
            ADDR_PEND: cfg_rdata = 32'(pend_eff);
            ADDR_STAT: cfg_rdata = 32'({in_svc, intr, vec_q});
            default:   cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pipe_intr_pic.sv
// Self-checking bench for pipe_intr_pic: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_pipe_intr_pic;

    localparam int NS = 8;
`ifdef PIC_SYNC_EN
    localparam int X = 2;
`else
    localparam int X = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_src = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        intr, inta = 1'b0, in_svc, eoi = 1'b0;
    logic [2:0]  vec_id;

    int n_checks = 0;
    int n_err    = 0;

    pipe_intr_pic #(.NSRC(NS), .IDW(3)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .intr(intr), .inta(inta),
        .vec_id(vec_id), .in_svc(in_svc), .eoi(eoi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model state: config, stored edge requests, previous line sample, and the
    // handshake as two flags (waiting for ack / being serviced) plus committed id.
    logic [7:0] m_mask, m_edge, m_pend, m_prev, m_s1, m_s2;
    logic       m_wait, m_serv, m_valid = 1'b0;
    int         m_id;

    function automatic logic [7:0] m_src();
        return (X != 0) ? m_s2 : irq_src;
    endfunction

    function automatic logic [7:0] m_pend_view();
        return (m_pend & m_edge) | (m_src() & ~m_edge);
    endfunction

    task automatic model_step();
        logic [7:0] s, rise, req, clr;
        if (rst) begin
            m_mask = '0; m_edge = '0; m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
            m_wait = 1'b0; m_serv = 1'b0; m_id = 0; m_valid = 1'b1;
            return;
        end
        s    = m_src();
        rise = s & ~m_prev;
        req  = m_pend_view() & m_mask;
        clr  = '0;
        if (cfg_we && cfg_addr == 2'd2) clr = cfg_wdata[7:0];
        if (m_wait) begin
            if (inta) begin
                m_wait = 1'b0; m_serv = 1'b1;
                clr[m_id] = 1'b1;
            end
        end else if (m_serv) begin
            if (eoi) m_serv = 1'b0;
        end else if (req != 0) begin
            m_wait = 1'b1;
            for (int i = 7; i >= 0; i--) if (req[i]) m_id = i;
        end
        m_pend = ((m_pend & ~clr) | rise) & m_edge;
        if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[7:0];
        if (cfg_we && cfg_addr == 2'd1) m_edge = cfg_wdata[7:0];
        m_prev = s;
        m_s2 = m_s1;
        m_s1 = irq_src;
    endtask

    function automatic logic [31:0] m_rdata();
        case (cfg_addr)
            2'd0: return {24'd0, m_mask};
            2'd1: return {24'd0, m_edge};
            2'd2: return {24'd0, m_pend_view()};
            default: return {27'd0, m_serv, m_wait, 3'(m_id)};
        endcase
    endfunction

    // Advance the model on each edge; compare every output mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (m_valid) begin
                chk("model_intr",   {31'd0, intr},   {31'd0, m_wait});
                chk("model_in_svc", {31'd0, in_svc}, {31'd0, m_serv});
                chk("model_vec_id", {29'd0, vec_id}, 32'(m_id));
                chk("model_rdata",  cfg_rdata,       m_rdata());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step(1);
        cfg_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        chk(name, cfg_rdata, exp);
    endtask

    task automatic pulse_inta();
        inta = 1'b1; step(1); inta = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; step(1); eoi = 1'b0;
    endtask

    task automatic out_chk(input string name, input logic ei, input logic es, input int ev);
        chk({name, "_intr"},   {31'd0, intr},   {31'd0, ei});
        chk({name, "_in_svc"}, {31'd0, in_svc}, {31'd0, es});
        chk({name, "_vec"},    {29'd0, vec_id}, 32'(ev));
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        out_chk("reset", 1'b0, 1'b0, 0);
        rd_chk("reset_mask", 2'd0, 32'h0);
        rd_chk("reset_stat", 2'd3, 32'h0);

        // 1: masked level source shows in PEND but never requests
        irq_src = 8'h08;
        step(1 + X);
        chk("t1_intr0", {31'd0, intr}, 32'd0);
        rd_chk("t1_pend", 2'd2, 32'h08);
        step(1);
        chk("t1_intr1", {31'd0, intr}, 32'd0);
        irq_src = 8'h00;
        step(3);

        // upper write-data bits are ignored
        wr(2'd0, 32'hABCD_EF00);
        rd_chk("wide_mask", 2'd0, 32'h0);

        // 2: single edge source, latency and handshake
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'hFF);
        irq_src = 8'h20;
        step(1 + X);
        rd_chk("t2_pend", 2'd2, 32'h20);
        chk("t2_intr_early", {31'd0, intr}, 32'd0);
        step(1);
        out_chk("t2_req", 1'b1, 1'b0, 5);
        rd_chk("t2_stat_req", 2'd3, 32'h0D);
        pulse_inta();
        out_chk("t2_svc", 1'b0, 1'b1, 5);
        rd_chk("t2_pend_clr", 2'd2, 32'h00);
        rd_chk("t2_stat_svc", 2'd3, 32'h15);
        irq_src = 8'h00;
        pulse_eoi();
        out_chk("t2_idle", 1'b0, 1'b0, 5);
        step(2 + X);

        // 3: simultaneous rises, priority order
        irq_src = 8'h44;
        step(2 + X);
        out_chk("t3_first", 1'b1, 1'b0, 2);
        pulse_inta();
        pulse_eoi();
        chk("t3_gap", {31'd0, intr}, 32'd0);
        step(1);
        out_chk("t3_second", 1'b1, 1'b0, 6);
        irq_src = 8'h00;
        pulse_inta();
        pulse_eoi();
        step(2 + X);

        // 4: committed vector is frozen against a later higher-priority request
        irq_src = 8'h10;
        step(2 + X);
        out_chk("t4_req4", 1'b1, 1'b0, 4);
        irq_src = 8'h11;
        step(2 + X);
        out_chk("t4_frozen", 1'b1, 1'b0, 4);
        pulse_inta();
        pulse_eoi();
        step(1);
        out_chk("t4_req0", 1'b1, 1'b0, 0);
        irq_src = 8'h00;
        pulse_inta();
        pulse_eoi();
        step(2 + X);

        // 5: level source re-requests after eoi; W1C has no effect on it
        wr(2'd1, 32'hFD);
        irq_src = 8'h02;
        step(1 + X);
        out_chk("t5_req", 1'b1, 1'b0, 1);
        pulse_inta();
        wr(2'd2, 32'h02);
        rd_chk("t5_pend_w1c", 2'd2, 32'h02);
        pulse_eoi();
        out_chk("t5_idle", 1'b0, 1'b0, 1);
        step(1);
        out_chk("t5_rereq", 1'b1, 1'b0, 1);
        irq_src = 8'h00;
        step(3);
        pulse_inta();
        pulse_eoi();
        step(2 + X);

        // 6: rise beats same-cycle W1C; reset during service
        wr(2'd1, 32'hFF);
        irq_src = 8'h08;
        step(X);
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h08;
        step(1);
        cfg_we = 1'b0;
        rd_chk("t6_set_wins", 2'd2, 32'h08);
        step(1);
        out_chk("t6_req", 1'b1, 1'b0, 3);
        pulse_inta();
        chk("t6_svc", {31'd0, in_svc}, 32'd1);
        irq_src = 8'h00;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        out_chk("t6_rst", 1'b0, 1'b0, 0);
        rd_chk("t6_pend", 2'd2, 32'h00);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) irq_src[$urandom_range(0, 7)] ^= 1'b1;
            inta      = ($urandom_range(0, 3) == 0);
            eoi       = ($urandom_range(0, 4) == 0);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = $urandom;
            if (cfg_we && cfg_addr == 2'd0 && $urandom_range(0, 1) == 0) cfg_wdata[7:0] = 8'hFF;
            rst       = ($urandom_range(0, 399) == 0);
            step(1);
        end
        inta = 1'b0; eoi = 1'b0; cfg_we = 1'b0; rst = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
